// File: rtl/edge_detect_filt_multi.sv
// ---------------------------------------------------------------------------
// edge_detect_filt_multi
//
// Multi-channel edge detector for asynchronous board-level signals (power
// good, presence, buttons, alert lines).  Each channel is synchronised, then
// glitch-filtered: the synced level must disagree with the accepted level for
// FILT_CYCLES consecutive clocks before it is taken.  Rise/fall pulses come
// from the filtered level.  A per-channel mode selects which edges are
// reported.  Reported edges are latched into a write-1-to-clear sticky flag,
// and the sticky flags are ORed into one interrupt.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_signal     [CH_NUM]     raw asynchronous inputs
//   i_edge_mode  [2*CH_NUM]   per channel {fall_en, rise_en}: 00 off, 01 rise,
//                             10 fall, 11 both
//   i_clr        [CH_NUM]     write-1-to-clear for o_sticky
//   o_filt       [CH_NUM]     synchronised and filtered level
//   o_pos        [CH_NUM]     1-cycle pulse on a filtered rising edge
//   o_neg        [CH_NUM]     1-cycle pulse on a filtered falling edge
//   o_edge       [CH_NUM]     o_pos/o_neg gated by i_edge_mode
//   o_sticky     [CH_NUM]     latched o_edge, held until cleared
//   o_irq        OR of all o_sticky bits
// ---------------------------------------------------------------------------
module edge_detect_filt_multi #(
  parameter int                CH_NUM      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILT_CYCLES = 4,
  parameter logic [CH_NUM-1:0] RST_VAL     = '0,
  parameter int                CNT_W       = $clog2(FILT_CYCLES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CH_NUM-1:0]     i_signal,
  input  logic [2*CH_NUM-1:0]   i_edge_mode,
  input  logic [CH_NUM-1:0]     i_clr,
  output logic [CH_NUM-1:0]     o_filt,
  output logic [CH_NUM-1:0]     o_pos,
  output logic [CH_NUM-1:0]     o_neg,
  output logic [CH_NUM-1:0]     o_edge,
  output logic [CH_NUM-1:0]     o_sticky,
  output logic                  o_irq
);

  // Last count value before a disagreement is accepted.  The counter clears
  // on acceptance, so it can never exceed this and never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   filt_p1;
    logic                   filt_p2;
    logic                   sticky_p3;
    logic                   pos;
    logic                   neg;
    logic                   edge_hit;
    logic [1:0]             mode;

    // ---- stage 0: synchroniser chain, MSB is the synced output ----
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync_p0 <= {SYNC_STAGES{RST_VAL[c]}};
      end else begin
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_signal[c]};
      end
    end

    // ---- stage 1: glitch filter ----
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_p1  <= '0;
        filt_p1 <= RST_VAL[c];
      end else if (sync_p0[SYNC_STAGES-1] == filt_p1) begin
        cnt_p1  <= '0;
      end else if (cnt_p1 == CNT_LAST) begin
        cnt_p1  <= '0;
        filt_p1 <= sync_p0[SYNC_STAGES-1];
      end else begin
        cnt_p1  <= cnt_p1 + CNT_W'(1);
      end
    end

    // ---- stage 2: delayed filtered level for edge decode ----
    // Reset to the same level as filt_p1 so releasing reset never pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        filt_p2 <= RST_VAL[c];
      end else begin
        filt_p2 <= filt_p1;
      end
    end

    assign pos      = filt_p1 & ~filt_p2;
    assign neg      = ~filt_p1 & filt_p2;
    assign mode     = i_edge_mode[2*c +: 2];
    assign edge_hit = (mode[0] & pos) | (mode[1] & neg);

    // ---- stage 3: sticky event flag, a new edge beats a clear ----
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sticky_p3 <= 1'b0;
      end else begin
        sticky_p3 <= edge_hit | (sticky_p3 & ~i_clr[c]);
      end
    end

    assign o_filt[c]   = filt_p1;
    assign o_pos[c]    = pos;
    assign o_neg[c]    = neg;
    assign o_edge[c]   = edge_hit;
    assign o_sticky[c] = sticky_p3;
  end

  assign o_irq = |o_sticky;

endmodule

// File: tb/tb_edge_detect_filt_multi.sv
// ---------------------------------------------------------------------------
// tb_edge_detect_filt_multi
//
// Directed bench for edge_detect_filt_multi.  u_dut uses default parameters
// (RST_VAL = 0); u_ff uses RST_VAL = 8'hFF with its inputs held high, sharing
// clock and reset.  Inputs change 1 ns after a rising edge; outputs are
// checked 1 ns after a rising edge.  "Edge N" below is the N-th rising edge
// that samples a new input level.
// ---------------------------------------------------------------------------
module tb_edge_detect_filt_multi;

  logic        clk;
  logic        rst;
  logic [7:0]  sig;
  logic [15:0] mode;
  logic [7:0]  clr;
  logic [7:0]  filt, pos, neg, edg, sticky;
  logic        irq;

  logic [7:0]  sig_ff;
  logic [15:0] mode_ff;
  logic [7:0]  clr_ff;
  logic [7:0]  filt_ff, pos_ff, neg_ff, edg_ff, sticky_ff;
  logic        irq_ff;

  int errors = 0;
  int checks = 0;
  logic ff_pulse_seen = 1'b0;

  edge_detect_filt_multi u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_signal   (sig),
    .i_edge_mode(mode),
    .i_clr      (clr),
    .o_filt     (filt),
    .o_pos      (pos),
    .o_neg      (neg),
    .o_edge     (edg),
    .o_sticky   (sticky),
    .o_irq      (irq)
  );

  edge_detect_filt_multi #(.RST_VAL(8'hFF)) u_ff (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_signal   (sig_ff),
    .i_edge_mode(mode_ff),
    .i_clr      (clr_ff),
    .o_filt     (filt_ff),
    .o_pos      (pos_ff),
    .o_neg      (neg_ff),
    .o_edge     (edg_ff),
    .o_sticky   (sticky_ff),
    .o_irq      (irq_ff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Any pulse from the RST_VAL=FF instance outside reset is a fault.
  always @(negedge clk) begin
    if (!rst && ((pos_ff | neg_ff) != 8'h00)) ff_pulse_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    sig     = 8'h00;
    clr     = 8'h00;
    // ch0 rise, ch1 off, ch2 fall, ch3 both
    mode    = 16'h00_00 | (16'h1 << 0) | (16'h0 << 2) | (16'h2 << 4) | (16'h3 << 6);
    sig_ff  = 8'hFF;
    mode_ff = 16'hFFFF;
    clr_ff  = 8'h00;

    // ---- reset state ----
    tick(3);
    chk("rst_filt",   32'(filt),   32'h00);
    chk("rst_pulses", 32'(pos | neg | edg), 32'h00);
    chk("rst_sticky", 32'(sticky), 32'h00);
    chk("rst_irq",    32'(irq),    32'h0);
    chk("rst_ff_filt", 32'(filt_ff), 32'hFF);
    rst = 1'b0;
    tick(2);

    // ---- 1: ch0 rising edge, mode 01 ----
    sig[0] = 1'b1;
    tick(5);
    chk("t1_e5_filt", 32'(filt[0]), 32'h0);
    chk("t1_e5_pos",  32'(pos[0]),  32'h0);
    tick(1);
    chk("t1_e6_filt",   32'(filt[0]),   32'h1);
    chk("t1_e6_pos",    32'(pos[0]),    32'h1);
    chk("t1_e6_edge",   32'(edg[0]),    32'h1);
    chk("t1_e6_neg",    32'(neg[0]),    32'h0);
    chk("t1_e6_sticky", 32'(sticky[0]), 32'h0);
    chk("t1_e6_irq",    32'(irq),       32'h0);
    tick(1);
    chk("t1_e7_pos",    32'(pos[0]),    32'h0);
    chk("t1_e7_edge",   32'(edg[0]),    32'h0);
    chk("t1_e7_sticky", 32'(sticky[0]), 32'h1);
    chk("t1_e7_irq",    32'(irq),       32'h1);

    // ---- 2: ch1 three-cycle glitch is rejected ----
    begin
      logic seen;
      seen = 1'b0;
      sig[1] = 1'b1;
      tick(3);
      sig[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        seen |= filt[1] | pos[1] | neg[1];
        tick(1);
      end
      chk("t2_glitch_ignored", 32'(seen), 32'h0);
    end
    // A full qualification afterwards needs exactly 6 edges, so the counter
    // must have returned to 0 after the glitch.
    sig[1] = 1'b1;
    tick(5);
    chk("t2_requal_e5_filt", 32'(filt[1]), 32'h0);
    tick(1);
    chk("t2_requal_e6_filt", 32'(filt[1]), 32'h1);
    chk("t2_requal_e6_pos",  32'(pos[1]),  32'h1);
    chk("t2_mode_off_edge",  32'(edg[1]),  32'h0);

    // ---- 3: ch2 falling-only mode ----
    sig[2] = 1'b1;
    tick(6);
    chk("t3_rise_pos",  32'(pos[2]), 32'h1);
    chk("t3_rise_edge", 32'(edg[2]), 32'h0);
    tick(1);
    chk("t3_rise_sticky", 32'(sticky[2]), 32'h0);
    tick(3);
    sig[2] = 1'b0;
    tick(6);
    chk("t3_fall_neg",    32'(neg[2]),    32'h1);
    chk("t3_fall_pos",    32'(pos[2]),    32'h0);
    chk("t3_fall_edge",   32'(edg[2]),    32'h1);
    chk("t3_fall_sticky", 32'(sticky[2]), 32'h0);
    tick(1);
    chk("t3_sticky_set",  32'(sticky[2]), 32'h1);

    // ---- 4: set beats clear, then clear alone ----
    sig[0] = 1'b0;
    tick(8);
    chk("t4_fall_filtered", 32'(filt[0]), 32'h0);
    chk("t4_sticky_held",   32'(sticky[0]), 32'h1);
    sig[0] = 1'b1;
    tick(6);
    chk("t4_edge_up", 32'(edg[0]), 32'h1);
    mode[1:0] = 2'b00;
    #1;
    chk("t4_mode_off_now", 32'(edg[0]), 32'h0);
    mode[1:0] = 2'b01;
    clr[0] = 1'b1;
    #1;
    chk("t4_mode_on_now", 32'(edg[0]), 32'h1);
    tick(1);
    clr[0] = 1'b0;
    chk("t4_set_wins", 32'(sticky[0]), 32'h1);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    chk("t4_clr_ch0",  32'(sticky[0]), 32'h0);
    chk("t4_irq_held", 32'(irq), 32'h1);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    chk("t4_sticky_all_clear", 32'(sticky), 32'h00);
    chk("t4_irq_low", 32'(irq), 32'h0);

    // ---- 6: reset in mid-qualification on ch3 ----
    sig[3] = 1'b1;
    tick(4);
    chk("t6_pre_rst_filt3", 32'(filt[3]), 32'h0);
    chk("t6_pre_rst_filt0", 32'(filt[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_async_filt", 32'(filt), 32'h00);
    chk("t6_async_ff",   32'(filt_ff), 32'hFF);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("t6_no_early_filt", 32'(filt[3]), 32'h0);
    chk("t6_no_early_pos",  32'(pos[3]),  32'h0);
    tick(1);
    chk("t6_requal_filt", 32'(filt[3]), 32'h1);
    chk("t6_requal_pos",  32'(pos[3]),  32'h1);
    chk("t6_requal_edge", 32'(edg[3]),  32'h1);
    tick(1);
    chk("t6_sticky", 32'(sticky[3]), 32'h1);
    chk("t6_irq",    32'(irq),       32'h1);

    // ---- 5: RST_VAL = FF instance never pulses ----
    tick(3);
    chk("t5_ff_filt",   32'(filt_ff),   32'hFF);
    chk("t5_ff_pulse",  32'(ff_pulse_seen), 32'h0);
    chk("t5_ff_sticky", 32'(sticky_ff), 32'h00);
    chk("t5_ff_irq",    32'(irq_ff),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
